pcg_dxsm: RTL and testbench



---
 rtl/pcg_pkg.sv | 8 +
 rtl/pcg_dxsm_perm.sv | 18 +
 rtl/pcg_dxsm.sv | 58 +++++
 tb/tb_pcg_dxsm.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pcg_pkg.sv
// Shared constants and types for the PCG64-DXSM generator.
package pcg_pkg;
  typedef logic [127:0] state_t;
  typedef logic [63:0]  word_t;

  localparam word_t  CHEAP_MULT        = 64'hDA942042E4DD58B5;
  localparam state_t INCREMENT_DEFAULT = 128'h5851F42D4C957F2D_14057B7EF767814F;
endpackage

// File: rtl/pcg_dxsm_perm.sv
// Combinational DXSM output permutation: 128-bit LCG state to 64-bit word.
module pcg_dxsm_perm
  import pcg_pkg::*;
(
  input  logic [127:0] state,
  output logic [63:0]  word
);
  word_t hi0, lo, hi1, hi2, hi3;

  always_comb begin
    hi0  = state[127:64];
    lo   = state[63:0] | 64'd1;
    hi1  = hi0 ^ (hi0 >> 32);
    hi2  = hi1 * CHEAP_MULT;
    hi3  = hi2 ^ (hi2 >> 48);
    word = hi3 * lo;
  end
endmodule

// File: rtl/pcg_dxsm.sv
// PCG64-DXSM generator: seeds on first enabled cycle after reset, then emits
// one word per enabled clock. Define PCG_VALID_EN to add the out_valid port.
module pcg_dxsm
  import pcg_pkg::*;
#(
  parameter logic [127:0] INCREMENT = INCREMENT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [127:0] data_in,
  output logic [63:0]  out
`ifdef PCG_VALID_EN
  ,
  output logic         out_valid
`endif
);
  localparam state_t INC  = INCREMENT | 128'd1;
  localparam state_t MULT = {64'd0, CHEAP_MULT};

  state_t state;
  state_t state_next;
  word_t  perm_word;
  logic   seeded;

  pcg_dxsm_perm u_perm (
    .state (state),
    .word  (perm_word)
  );

  always_comb begin
    state_next = state * MULT + INC;
  end

  // Output is taken from the pre-advance state, matching PCG64DXSM ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= '0;
      seeded <= 1'b0;
      out    <= '0;
    end else if (en) begin
      if (!seeded) begin
        state  <= data_in;
        seeded <= 1'b1;
      end else begin
        state <= state_next;
        out   <= perm_word;
      end
    end
  end

`ifdef PCG_VALID_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= en && seeded;
  end
`endif
endmodule

// File: tb/tb_pcg_dxsm.sv
// Scoreboard bench for pcg_dxsm against an arithmetic PCG64-DXSM model.
module tb_pcg_dxsm;
  localparam logic [63:0]  CM   = 64'hDA942042E4DD58B5;
  localparam logic [127:0] INC  = 128'h5851F42D4C957F2D_14057B7EF767814F | 128'd1;
  localparam logic [127:0] SEED = 128'h0123456789ABCDEF_FEDCBA9876543210;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [127:0] data_in = '0;
  logic [63:0]  out;
  logic         out_valid_dut;

  pcg_dxsm #(.INCREMENT(128'h5851F42D4C957F2D_14057B7EF767814F)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .data_in (data_in),
    .out     (out)
`ifdef PCG_VALID_EN
    ,
    .out_valid (out_valid_dut)
`endif
  );
`ifndef PCG_VALID_EN
  assign out_valid_dut = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] out;
    logic        valid;
    string       tag;
  } exp_t;

  exp_t q[$];
  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model state
  logic [127:0] m_state = '0;
  logic         m_seeded = 1'b0;
  logic [63:0]  m_out = '0;
  logic         m_valid = 1'b0;

  function automatic logic [63:0] dxsm(input logic [127:0] s);
    logic [63:0] hi, lo;
    hi = s[127:64];
    lo = s[63:0] | 64'd1;
    hi = hi ^ (hi >> 32);
    hi = hi * CM;
    hi = hi ^ (hi >> 48);
    return hi * lo;
  endfunction

  task automatic model_edge(input string tag);
    if (rst) begin
      m_state = '0; m_seeded = 1'b0; m_out = '0; m_valid = 1'b0;
    end else if (!en) begin
      m_valid = 1'b0;
    end else if (!m_seeded) begin
      m_state = data_in; m_seeded = 1'b1; m_valid = 1'b0;
    end else begin
      m_out   = dxsm(m_state);
      m_state = m_state * {64'd0, CM} + INC;
      m_valid = 1'b1;
    end
    q.push_back('{out: m_out, valid: m_valid, tag: tag});
  endtask

  // Drive inputs, wait for the edge, record expectation.
  task automatic tick(input logic e, input logic [127:0] d, input string tag);
    en = e;
    data_in = d;
    @(posedge clk);
    model_edge(tag);
    #1;
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests++;
    if (out !== 64'd0) begin
      fails++;
      $display("FAIL %s async_out got=%h exp=%h", tag, out, 64'd0);
    end
    @(posedge clk);
    model_edge({tag, "_held"});
    #1;
    rst = 1'b0;
  endtask

  // Monitor: pops one expectation per edge, compares on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        tests++;
        if (out !== e.out) begin
          fails++;
          $display("FAIL %s out got=%h exp=%h", e.tag, out, e.out);
        end
`ifdef PCG_VALID_EN
        tests++;
        if (out_valid_dut !== e.valid) begin
          fails++;
          $display("FAIL %s out_valid got=%b exp=%b", e.tag, out_valid_dut, e.valid);
        end
`endif
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    // Power-on reset
    rst = 1'b1;
    #3;
    tests++;
    if (out !== 64'd0) begin
      fails++;
      $display("FAIL reset_out got=%h exp=%h", out, 64'd0);
    end
    @(posedge clk);
    model_edge("reset");
    #1;
    rst = 1'b0;

    // Zero seed: seed edge, dxsm(0)=0, then dxsm(INCREMENT)
    tick(1'b1, 128'd0, "zero_seed");
    tick(1'b1, 128'd0, "zero_gen1");
    tick(1'b1, 128'd0, "zero_gen2");
    tick(1'b1, 128'd0, "zero_gen3");

    // Known seed, 11 edges, data_in altered after the seed edge
    async_reset("rst_before_seed");
    tick(1'b1, SEED, "seed_load");
    for (int i = 0; i < 10; i++)
      tick(1'b1, {$urandom, $urandom, $urandom, $urandom}, "seed_gen");

    // en held low for 3 cycles mid-sequence
    for (int i = 0; i < 3; i++)
      tick(1'b0, {$urandom, $urandom, $urandom, $urandom}, "en_low");
    for (int i = 0; i < 4; i++)
      tick(1'b1, {$urandom, $urandom, $urandom, $urandom}, "resume");

    // Mid-run reset, reseed from a random value
    async_reset("rst_midrun");
    tick(1'b1, {$urandom, $urandom, $urandom, $urandom}, "reseed");
    tick(1'b1, '0, "reseed_gen");

    // Randomized enable/data with occasional reset
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
      tick(1'($urandom_range(0, 3) != 0), {$urandom, $urandom, $urandom, $urandom}, "rand");
    end
    tick(1'b0, '0, "tail");

    // Drain the scoreboard
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain pending=%0d exp=%0d", q.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
